// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals shared by mem_port_arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus memory around it.
interface mem_port_arbiter_if;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_valid;
  logic        ls_ready;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic        ls_rsp_valid;
  logic [63:0] ls_rsp_data;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  if_valid, if_addr, ls_valid, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_ready, if_rsp_valid, if_rsp_data, ls_ready, ls_rsp_valid, ls_rsp_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_valid, if_addr, ls_valid, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_ready, if_rsp_valid, if_rsp_data, ls_ready, ls_rsp_valid, ls_rsp_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency 64-bit memory between instruction fetch and load/store, one access at a time.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; otherwise LS has priority with an IF starvation guard.
module mem_port_arbiter #(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      state;
  state_t      state_next;
  logic        owner_ls;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] data_q;
  logic [3:0]  lat_cnt;
  logic        grant_if;
  logic        grant_ls;
  logic        prefer_if;

`ifdef MEM_PORT_ARB_RR_EN
  // Remembers which port won last so a conflict goes to the other one; reset favours LS.
  logic last_ls;

  assign prefer_if = last_ls;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ls <= 1'b0;
    end else if (grant_if) begin
      last_ls <= 1'b0;
    end else if (grant_ls) begin
      last_ls <= 1'b1;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign prefer_if = (starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_if) begin
      starve_cnt <= 4'd0;
    end else if (grant_ls && bus.if_valid && starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_valid && bus.ls_valid) begin
          grant_if = prefer_if;
          grant_ls = !prefer_if;
        end else begin
          grant_if = bus.if_valid;
          grant_ls = bus.ls_valid;
        end
        if (grant_if || grant_ls) state_next = ISSUE;
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (lat_cnt == LAT) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner_ls <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      data_q   <= 64'd0;
      lat_cnt  <= 4'd0;
    end else begin
      state <= state_next;
      if (grant_if) begin
        owner_ls <= 1'b0;
        we_q     <= 1'b0;
        addr_q   <= {bus.if_addr[63:2], 2'b00};
        wdata_q  <= 64'd0;
      end else if (grant_ls) begin
        owner_ls <= 1'b1;
        we_q     <= bus.ls_we;
        addr_q   <= bus.ls_addr;
        wdata_q  <= bus.ls_wdata;
      end
      // Latency counter starts at 1 on the issue cycle; rdata is captured on the cycle it matches.
      if (state == ISSUE) begin
        lat_cnt <= 4'd1;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 4'd1;
        if (lat_cnt == LAT) data_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_ready     = grant_if;
  assign bus.ls_ready     = grant_ls;
  assign bus.mem_req      = (state == ISSUE);
  assign bus.mem_we       = (state == ISSUE) && we_q;
  assign bus.mem_addr     = (state == ISSUE) ? addr_q  : 64'd0;
  assign bus.mem_wdata    = (state == ISSUE) ? wdata_q : 64'd0;
  assign bus.if_rsp_valid = (state == RESP) && !owner_ls;
  assign bus.ls_rsp_valid = (state == RESP) && owner_ls;
  assign bus.if_rsp_data  = !bus.if_rsp_valid ? 32'd0 :
                            (addr_q[2] ? data_q[63:32] : data_q[31:0]);
  assign bus.ls_rsp_data  = (bus.ls_rsp_valid && !we_q) ? data_q : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3, each behind a small memory model.
// Grant-order expectations follow MEM_PORT_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   passes = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_LIMIT(4)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h2AAA_BBBF, a[31:0] ^ 32'h4CCC_DDD9};
  endfunction

  // Memory models: data appears for exactly one cycle, MEM_LAT cycles after mem_req, zero otherwise.
  logic [63:0] pend_addr_a = 64'd0;
  logic [63:0] pend_addr_b = 64'd0;
  int          lat_a = 0;
  int          lat_b = 0;

  always @(posedge clk) begin
    if (bus_a.mem_req) begin
      pend_addr_a <= bus_a.mem_addr;
      lat_a       <= 1;
    end else if (lat_a > 0) begin
      lat_a <= lat_a - 1;
    end
    if (bus_b.mem_req) begin
      pend_addr_b <= bus_b.mem_addr;
      lat_b       <= 3;
    end else if (lat_b > 0) begin
      lat_b <= lat_b - 1;
    end
  end

  assign bus_a.mem_rdata = (lat_a == 1) ? mem_word(pend_addr_a) : 64'd0;
  assign bus_b.mem_rdata = (lat_b == 1) ? mem_word(pend_addr_b) : 64'd0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitors: exclusive ready, mem_req exactly one cycle after accept, one owner-matched rsp per accept.
  logic acc_prev_a = 1'b0, pend_a = 1'b0, pend_ls_a = 1'b0;
  logic acc_prev_b = 1'b0, pend_b = 1'b0, pend_ls_b = 1'b0;

  always @(negedge clk) begin
    check_output("a_ready_excl", 64'(bus_a.if_ready & bus_a.ls_ready), 64'd0);
    check_output("a_req_after_accept", 64'(bus_a.mem_req), 64'(acc_prev_a));
    if (bus_a.if_rsp_valid || bus_a.ls_rsp_valid) begin
      check_output("a_rsp_owner", {61'd0, pend_a, bus_a.if_rsp_valid, bus_a.ls_rsp_valid},
                   {61'd0, 1'b1, !pend_ls_a, pend_ls_a});
      pend_a = 1'b0;
    end
    if (rst_a) begin
      acc_prev_a = 1'b0;
      pend_a     = 1'b0;
    end else begin
      acc_prev_a = (bus_a.if_valid & bus_a.if_ready) | (bus_a.ls_valid & bus_a.ls_ready);
      if (acc_prev_a) begin
        pend_a    = 1'b1;
        pend_ls_a = bus_a.ls_valid & bus_a.ls_ready;
      end
    end
  end

  always @(negedge clk) begin
    check_output("b_ready_excl", 64'(bus_b.if_ready & bus_b.ls_ready), 64'd0);
    check_output("b_req_after_accept", 64'(bus_b.mem_req), 64'(acc_prev_b));
    if (bus_b.if_rsp_valid || bus_b.ls_rsp_valid) begin
      check_output("b_rsp_owner", {61'd0, pend_b, bus_b.if_rsp_valid, bus_b.ls_rsp_valid},
                   {61'd0, 1'b1, !pend_ls_b, pend_ls_b});
      pend_b = 1'b0;
    end
    if (rst_b) begin
      acc_prev_b = 1'b0;
      pend_b     = 1'b0;
    end else begin
      acc_prev_b = (bus_b.if_valid & bus_b.if_ready) | (bus_b.ls_valid & bus_b.ls_ready);
      if (acc_prev_b) begin
        pend_b    = 1'b1;
        pend_ls_b = bus_b.ls_valid & bus_b.ls_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] if_addr3;
    logic [63:0] ls_addr3;
    logic [63:0] word;
    logic [31:0] exp_if_word;
    logic [63:0] exp_ls_word;
    logic [9:0]  exp_order;
    int          got;
    int          guard;
    int          if_rsps;
    int          ls_rsps;

    bus_a.if_valid = 1'b0; bus_a.if_addr = 64'd0; bus_a.ls_valid = 1'b0;
    bus_a.ls_we = 1'b0; bus_a.ls_addr = 64'd0; bus_a.ls_wdata = 64'd0;
    bus_b.if_valid = 1'b0; bus_b.if_addr = 64'd0; bus_b.ls_valid = 1'b0;
    bus_b.ls_we = 1'b0; bus_b.ls_addr = 64'd0; bus_b.ls_wdata = 64'd0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_if_ready", 64'(bus_a.if_ready), 64'd0);
    check_output("rst_ls_ready", 64'(bus_a.ls_ready), 64'd0);
    check_output("rst_mem_req", 64'(bus_a.mem_req), 64'd0);
    check_output("rst_mem_addr", bus_a.mem_addr, 64'd0);
    check_output("rst_if_rsp_valid", 64'(bus_a.if_rsp_valid), 64'd0);
    check_output("rst_ls_rsp_valid", 64'(bus_a.ls_rsp_valid), 64'd0);
    check_output("rst_ls_rsp_data", bus_a.ls_rsp_data, 64'd0);

    // Fetch only, MEM_LAT=1: accept at T, response at T+3 from the upper half (addr bit 2 set).
    next_cycle();
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.if_valid = 1'b1; bus_a.if_addr = 64'h8000_0004;
    @(negedge clk);
    check_output("t1_if_ready", 64'(bus_a.if_ready), 64'd1);
    check_output("t1_ls_ready", 64'(bus_a.ls_ready), 64'd0);
    next_cycle();
    bus_a.if_valid = 1'b0;
    @(negedge clk);
    check_output("t1_mem_req", 64'(bus_a.mem_req), 64'd1);
    check_output("t1_mem_addr", bus_a.mem_addr, 64'h8000_0004);
    check_output("t1_mem_we", 64'(bus_a.mem_we), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("t1_rsp_early", 64'(bus_a.if_rsp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("t1_rsp_valid", 64'(bus_a.if_rsp_valid), 64'd1);
    check_output("t1_rsp_data", 64'(bus_a.if_rsp_data), 64'hAAAA_BBBB);
    check_output("t1_ls_rsp_quiet", 64'(bus_a.ls_rsp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("t1_rsp_pulse_end", 64'(bus_a.if_rsp_valid), 64'd0);

    // Store: write fields on the bus at T+1, acknowledgement with zero data at T+3.
    next_cycle();
    bus_a.ls_valid = 1'b1; bus_a.ls_we = 1'b1;
    bus_a.ls_addr = 64'h8000_1000; bus_a.ls_wdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    check_output("t2_ls_ready", 64'(bus_a.ls_ready), 64'd1);
    check_output("t2_if_ready", 64'(bus_a.if_ready), 64'd0);
    next_cycle();
    bus_a.ls_valid = 1'b0; bus_a.ls_we = 1'b0;
    @(negedge clk);
    check_output("t2_mem_req", 64'(bus_a.mem_req), 64'd1);
    check_output("t2_mem_we", 64'(bus_a.mem_we), 64'd1);
    check_output("t2_mem_addr", bus_a.mem_addr, 64'h8000_1000);
    check_output("t2_mem_wdata", bus_a.mem_wdata, 64'h1122_3344_5566_7788);
    next_cycle();
    @(negedge clk);
    check_output("t2_rsp_early", 64'(bus_a.ls_rsp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("t2_rsp_valid", 64'(bus_a.ls_rsp_valid), 64'd1);
    check_output("t2_rsp_data", bus_a.ls_rsp_data, 64'd0);
    check_output("t2_if_rsp_quiet", 64'(bus_a.if_rsp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("t2_rsp_pulse_end", 64'(bus_a.ls_rsp_valid), 64'd0);

    // Both ports requesting continuously after a fresh reset: check grant order and response data.
    next_cycle();
    rst_a = 1'b1;
    next_cycle();
    rst_a = 1'b0;
    if_addr3 = 64'h8000_0010;
    ls_addr3 = 64'h8000_2008;
    word = mem_word(if_addr3);
    exp_if_word = word[31:0];
    exp_ls_word = mem_word(ls_addr3);
`ifdef MEM_PORT_ARB_RR_EN
    exp_order = 10'b10_1010_1010;
`else
    exp_order = 10'b10_0001_0000;
`endif
    bus_a.if_valid = 1'b1; bus_a.if_addr = if_addr3;
    bus_a.ls_valid = 1'b1; bus_a.ls_we = 1'b0; bus_a.ls_addr = ls_addr3;
    got = 0; guard = 0; if_rsps = 0; ls_rsps = 0;
    while (got < 10 && guard < 200) begin
      @(negedge clk);
      if (bus_a.if_rsp_valid) begin
        check_output("t3_if_data", 64'(bus_a.if_rsp_data), 64'(exp_if_word));
        if_rsps++;
      end
      if (bus_a.ls_rsp_valid) begin
        check_output("t3_ls_data", bus_a.ls_rsp_data, exp_ls_word);
        ls_rsps++;
      end
      if (bus_a.if_ready || bus_a.ls_ready) begin
        check_output($sformatf("t3_grant%0d_is_if", got), 64'(bus_a.if_ready), 64'(exp_order[got]));
        got++;
      end
      guard++;
      next_cycle();
    end
    bus_a.if_valid = 1'b0; bus_a.ls_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.if_rsp_valid) begin
        check_output("t3_if_data", 64'(bus_a.if_rsp_data), 64'(exp_if_word));
        if_rsps++;
      end
      if (bus_a.ls_rsp_valid) begin
        check_output("t3_ls_data", bus_a.ls_rsp_data, exp_ls_word);
        ls_rsps++;
      end
      next_cycle();
    end
    check_output("t3_grant_count", 64'(got), 64'd10);
    check_output("t3_if_rsp_count", 64'(if_rsps), 64'($countones(exp_order)));
    check_output("t3_ls_rsp_count", 64'(ls_rsps), 64'(10 - $countones(exp_order)));

    // MEM_LAT=3 load interrupted by reset while waiting; a later fetch completes at T+5.
    bus_b.ls_valid = 1'b1; bus_b.ls_we = 1'b0; bus_b.ls_addr = 64'h8000_3000;
    @(negedge clk);
    check_output("t5_ls_ready", 64'(bus_b.ls_ready), 64'd1);
    next_cycle();
    bus_b.ls_valid = 1'b0;
    @(negedge clk);
    check_output("t5_mem_req", 64'(bus_b.mem_req), 64'd1);
    next_cycle();
    @(negedge clk);
    check_output("t5_wait1_rsp", 64'(bus_b.ls_rsp_valid), 64'd0);
    next_cycle();
    rst_b = 1'b1;
    @(negedge clk);
    check_output("t5_wait2_rsp", 64'(bus_b.ls_rsp_valid), 64'd0);
    next_cycle();
    rst_b = 1'b0;
    @(negedge clk);
    check_output("t5_post_mem_req", 64'(bus_b.mem_req), 64'd0);
    check_output("t5_post_mem_we", 64'(bus_b.mem_we), 64'd0);
    check_output("t5_post_mem_addr", bus_b.mem_addr, 64'd0);
    check_output("t5_post_mem_wdata", bus_b.mem_wdata, 64'd0);
    check_output("t5_post_ls_rsp", 64'(bus_b.ls_rsp_valid), 64'd0);
    check_output("t5_post_ls_data", bus_b.ls_rsp_data, 64'd0);
    check_output("t5_post_if_rsp", 64'(bus_b.if_rsp_valid), 64'd0);
    check_output("t5_post_ready", 64'({bus_b.if_ready, bus_b.ls_ready}), 64'd0);
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      check_output("t5_dropped_rsp", 64'(bus_b.ls_rsp_valid), 64'd0);
    end
    next_cycle();
    bus_b.if_valid = 1'b1; bus_b.if_addr = 64'h8000_0104;
    @(negedge clk);
    check_output("t5_if_ready", 64'(bus_b.if_ready), 64'd1);
    next_cycle();
    bus_b.if_valid = 1'b0;
    @(negedge clk);
    check_output("t5_if_mem_addr", bus_b.mem_addr, 64'h8000_0104);
    for (int k = 2; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      check_output($sformatf("t5_if_rsp_early%0d", k), 64'(bus_b.if_rsp_valid), 64'd0);
    end
    next_cycle();
    @(negedge clk);
    check_output("t5_if_rsp_valid", 64'(bus_b.if_rsp_valid), 64'd1);
    check_output("t5_if_rsp_data", 64'(bus_b.if_rsp_data), 64'hAAAA_BABB);
    next_cycle();
    @(negedge clk);
    check_output("t5_if_rsp_pulse_end", 64'(bus_b.if_rsp_valid), 64'd0);

    check_output("a_no_pending", 64'(pend_a), 64'd0);
    check_output("b_no_pending", 64'(pend_b), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
